// File: rtl/ddr3_rd_capture_ctrl.sv
// DDR3 BL8 read capture sequencer.
// Grants scheduler read requests, times the read latency to the one-cycle
// `listen` arm pulse, waits a settle delay, then walks the 8-deep ring buffer
// read pointer and returns the burst as a registered, tagged word stream.
module ddr3_rd_capture_ctrl #(
    parameter int RL        = 11,  // grant -> listen, 2..31
    parameter int DRAIN_DLY = 2,   // listen -> first read_ptr drive, 1..7
    parameter int MIN_GAP   = 8,   // minimum grant spacing, 8..15
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_gnt,
    output logic              listen,
    output logic [2:0]        read_ptr,
    input  logic [DATA_W-1:0] buf_dout,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [TAG_W-1:0]  rd_tag_out,
    output logic              busy,
    output logic              err_ovf
);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    localparam int TQ_DEPTH = 4;

    // Grant spacing
    logic [3:0]           gap_q, gap_d;
    logic                 gap_ok;

    // Latency and settle delay lines
    logic [RL-1:0]        lat_q;
    logic [DRAIN_DLY-1:0] settle_q;
    logic                 drain_start;

    // Tag queue
    logic [TAG_W-1:0]     tagq_mem [TQ_DEPTH];
    logic [1:0]           tq_wr_q, tq_rd_q;
    logic [2:0]           tq_cnt_q, tq_cnt_d;
    logic                 tagq_full, tq_push, tq_pop;
    logic                 err_ovf_q;

    // Drain FSM
    state_t               state_q;
    logic [2:0]           ptr_q;
    logic                 rd_valid_q, rd_last_q;
    logic [DATA_W-1:0]    rd_data_q;

    assign gap_ok    = (gap_q == 4'd0);
    assign tagq_full = (tq_cnt_q == 3'(TQ_DEPTH));
    assign rd_gnt    = rd_req & gap_ok & ~tagq_full;
    assign tq_push   = rd_gnt;
    assign tq_pop    = rd_last_q & (tq_cnt_q != 3'd0);

    // Gap counter next state: reload on grant, otherwise count down to zero
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gap_d = gap_q;
        if (rd_gnt) begin
            gap_d = 4'(MIN_GAP - 1);
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    // Gap counter register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            gap_q <= 4'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // Latency line: the grant travels RL stages; the last stage is `listen`
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_q <= '0;
        end else begin
            lat_q[0] <= rd_gnt;
            for (int i = 1; i < RL; i++) begin
                lat_q[i] <= lat_q[i-1];
            end
        end
    end

    assign listen = lat_q[RL-1];

    // Settle line: delays `listen` until the strobe-captured data is stable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= '0;
        end else begin
            settle_q[0] <= listen;
            for (int i = 1; i < DRAIN_DLY; i++) begin
                settle_q[i] <= settle_q[i-1];
            end
        end
    end

    assign drain_start = settle_q[DRAIN_DLY-1];

    // Tag storage written on grant
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; only the pointers and count need a known value.
        if (tq_push && !tagq_full) begin
            tagq_mem[tq_wr_q] <= rd_tag;
        end
    end

    // Tag queue occupancy next state
    always_comb begin
        tq_cnt_d = tq_cnt_q;
        unique case ({tq_push, tq_pop})
            2'b10:   tq_cnt_d = tq_cnt_q + 3'd1;
            2'b01:   tq_cnt_d = tq_cnt_q - 3'd1;
            default: tq_cnt_d = tq_cnt_q;
        endcase
    end

    // Tag queue pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tq_wr_q   <= 2'd0;
            tq_rd_q   <= 2'd0;
            tq_cnt_q  <= 3'd0;
            err_ovf_q <= 1'b0;
        end else begin
            if (tq_push && !tagq_full) begin
                tq_wr_q <= tq_wr_q + 2'd1;
            end
            if (tq_pop) begin
                tq_rd_q <= tq_rd_q + 2'd1;
            end
            // A push that loses its entry must never happen; flag it if it does
            tq_cnt_q  <= (tq_push && tagq_full) ? tq_cnt_q : tq_cnt_d;
            err_ovf_q <= err_ovf_q | (tq_push & tagq_full);
        end
    end

    // Drain FSM: the drain_start cycle already reads word 0, so word k is
    // registered one cycle after read_ptr shows k
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'd0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (drain_start) begin
                        rd_data_q  <= buf_dout;
                        rd_valid_q <= 1'b1;
                        ptr_q      <= 3'd1;
                        state_q    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    rd_data_q  <= buf_dout;
                    rd_valid_q <= 1'b1;
                    if (ptr_q == 3'd7) begin
                        rd_last_q <= 1'b1;
                        ptr_q     <= 3'd0;
                        state_q   <= S_IDLE;
                    end else begin
                        ptr_q <= ptr_q + 3'd1;
                    end
                end
                default: begin
                    ptr_q   <= 3'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign read_ptr   = ptr_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign err_ovf    = err_ovf_q;
    // Head tag is shown only while a read is queued so the idle value is zero
    assign rd_tag_out = (tq_cnt_q != 3'd0) ? tagq_mem[tq_rd_q] : '0;
    assign busy       = (|lat_q) | (|settle_q) | (state_q != S_IDLE) | rd_valid_q;

endmodule

// File: tb/tb_ddr3_rd_capture_ctrl.sv
// Bench for ddr3_rd_capture_ctrl: three instances (RL=11/DLY=2, RL=31/DLY=2,
// RL=2/DLY=1) share clock and reset. A scoreboard per instance receives eight
// expected words on every grant and compares them as rd_valid words appear.
module tb_ddr3_rd_capture_ctrl;

    localparam int N_DUT  = 3;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [N_DUT-1:0]     rd_req, rd_gnt, listen, rd_valid, rd_last, busy, err_ovf;
    logic [TAG_W-1:0]     rd_tag     [N_DUT];
    logic [TAG_W-1:0]     rd_tag_out [N_DUT];
    logic [2:0]           read_ptr   [N_DUT];
    logic [DATA_W-1:0]    buf_dout   [N_DUT];
    logic [DATA_W-1:0]    rd_data    [N_DUT];

    int unsigned cyc;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned       cyc;
        logic [DATA_W-1:0] data;
        logic              last;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    // Cycle counter, zeroed by reset so scenario cycles are easy to read
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    for (genvar g = 0; g < N_DUT; g++) begin : gen_dut
        localparam int P_RL = (g == 0) ? 11 : (g == 1) ? 31 : 2;
        localparam int P_DD = (g == 2) ? 1 : 2;

        exp_t sb_q[$];
        exp_t e_push, e_pop;

        ddr3_rd_capture_ctrl #(
            .RL(P_RL), .DRAIN_DLY(P_DD), .MIN_GAP(8), .TAG_W(TAG_W), .DATA_W(DATA_W)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .rd_req    (rd_req[g]),
            .rd_tag    (rd_tag[g]),
            .rd_gnt    (rd_gnt[g]),
            .listen    (listen[g]),
            .read_ptr  (read_ptr[g]),
            .buf_dout  (buf_dout[g]),
            .rd_valid  (rd_valid[g]),
            .rd_data   (rd_data[g]),
            .rd_last   (rd_last[g]),
            .rd_tag_out(rd_tag_out[g]),
            .busy      (busy[g]),
            .err_ovf   (err_ovf[g])
        );

        // Ring buffer model: low byte holds the pointer, high byte the cycle it was read
        assign buf_dout[g] = {cyc[7:0], 5'd0, read_ptr[g]};

        // Scoreboard: push eight words per grant, pop one per rd_valid
        always @(negedge clk) begin
            if (!reset_n) begin
                sb_q.delete();
            end else begin
                if (rd_gnt[g]) begin
                    for (int k = 0; k < 8; k++) begin
                        e_push.cyc  = cyc + P_RL + P_DD + 1 + k;
                        e_push.data = {8'(cyc + P_RL + P_DD + k), 5'd0, 3'(k)};
                        e_push.last = (k == 7);
                        e_push.tag  = rd_tag[g];
                        sb_q.push_back(e_push);
                    end
                end
                if (rd_valid[g]) begin
                    if (sb_q.size() == 0) begin
                        check($sformatf("d%0d_unexpected_valid", g), 32'(rd_valid[g]), 32'd0);
                    end else begin
                        e_pop = sb_q.pop_front();
                        check($sformatf("d%0d_word_cycle", g), 32'(cyc), 32'(e_pop.cyc));
                        check($sformatf("d%0d_word_data", g), 32'(rd_data[g]), 32'(e_pop.data));
                        check($sformatf("d%0d_word_last", g), 32'(rd_last[g]), 32'(e_pop.last));
                        check($sformatf("d%0d_word_tag", g), 32'(rd_tag_out[g]), 32'(e_pop.tag));
                    end
                end else begin
                    check($sformatf("d%0d_last_idle", g), 32'(rd_last[g]), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int g, input string pfx);
        check({pfx, "_gnt"},      32'(rd_gnt[g]),     32'd0);
        check({pfx, "_listen"},   32'(listen[g]),     32'd0);
        check({pfx, "_valid"},    32'(rd_valid[g]),   32'd0);
        check({pfx, "_last"},     32'(rd_last[g]),    32'd0);
        check({pfx, "_busy"},     32'(busy[g]),       32'd0);
        check({pfx, "_err_ovf"},  32'(err_ovf[g]),    32'd0);
        check({pfx, "_read_ptr"}, 32'(read_ptr[g]),   32'd0);
        check({pfx, "_rd_data"},  32'(rd_data[g]),    32'd0);
        check({pfx, "_tag_out"},  32'(rd_tag_out[g]), 32'd0);
    endtask

    // Bounded wait for an instance to go idle; an expired budget is a failure
    task automatic wait_idle(input int g);
        int n = 0;
        while (busy[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("d%0d_idle_timeout", g), 32'(busy[g]), 32'd0);
    endtask

    // One isolated read: timing of grant, listen, read_ptr, rd_valid and busy
    task automatic run_single(input int g, input logic [TAG_W-1:0] tag, input int rl, input int dd);
        int unsigned base;
        step();
        rd_req[g] = 1'b1;
        rd_tag[g] = tag;
        @(negedge clk);
        base = cyc;
        check($sformatf("d%0d_single_gnt", g), 32'(rd_gnt[g]), 32'd1);
        step();
        rd_req[g] = 1'b0;
        rd_tag[g] = ~tag;
        for (int t = 1; t <= rl + dd + 11; t++) begin
            @(negedge clk);
            check($sformatf("d%0d_single_listen_t%0d", g, t), 32'(listen[g]), 32'(t == rl));
            check($sformatf("d%0d_single_ptr_t%0d", g, t), 32'(read_ptr[g]),
                  (t >= rl + dd && t <= rl + dd + 7) ? 32'(t - rl - dd) : 32'd0);
            check($sformatf("d%0d_single_valid_t%0d", g, t), 32'(rd_valid[g]),
                  32'(t >= rl + dd + 1 && t <= rl + dd + 8));
            check($sformatf("d%0d_single_busy_t%0d", g, t), 32'(busy[g]), 32'(t <= rl + dd + 8));
            check($sformatf("d%0d_single_cycle", g), cyc, base + 32'(t));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        reset_n = 1'b0;
        rd_req  = '0;
        for (int i = 0; i < N_DUT; i++) rd_tag[i] = '0;

        // Reset state of every instance
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) check_zero(i, $sformatf("d%0d_reset", i));
        step();
        step();
        reset_n = 1'b1;

        // Scenario 1: single read with tag 5
        run_single(0, 4'd5, 11, 2);
        check("s1_drained", 32'(gen_dut[0].sb_q.size()), 32'd0);

        // Scenario 2: request held, grants every 8 cycles, tag changing every cycle
        step();
        rd_req[0] = 1'b1;
        for (int t = 0; t < 32; t++) begin
            rd_tag[0] = 4'(t + t / 8);
            @(negedge clk);
            check($sformatf("s2_gnt_t%0d", t), 32'(rd_gnt[0]), 32'((t % 8) == 0));
            step();
        end
        rd_req[0] = 1'b0;
        wait_idle(0);
        check("s2_drained", 32'(gen_dut[0].sb_q.size()), 32'd0);

        // Scenario 3: second request at cycle 3 waits for the gap, then is granted
        step();
        rd_req[0] = 1'b1;
        rd_tag[0] = 4'd3;
        @(negedge clk);
        base = cyc;
        check("s3_first_gnt", 32'(rd_gnt[0]), 32'd1);
        step();
        rd_req[0] = 1'b0;
        step();
        step();
        rd_req[0] = 1'b1;
        rd_tag[0] = 4'd12;
        for (int t = 3; t <= 8; t++) begin
            @(negedge clk);
            check($sformatf("s3_gnt_t%0d", t), 32'(rd_gnt[0]), 32'(t == 8));
            check("s3_cycle", cyc, base + 32'(t));
        end
        step();
        rd_req[0] = 1'b0;
        wait_idle(0);
        check("s3_drained", 32'(gen_dut[0].sb_q.size()), 32'd0);

        // Scenario 4: RL=31, request held; the 5th grant waits for the first rd_last
        step();
        rd_req[1] = 1'b1;
        for (int t = 0; t < 70; t++) begin
            rd_tag[1] = 4'(t / 2);
            @(negedge clk);
            check($sformatf("s4_gnt_t%0d", t), 32'(rd_gnt[1]),
                  32'((t < 32 && (t % 8) == 0) || (t >= 42 && ((t - 42) % 8) == 0)));
            check($sformatf("s4_err_ovf_t%0d", t), 32'(err_ovf[1]), 32'd0);
            step();
        end
        rd_req[1] = 1'b0;
        wait_idle(1);
        check("s4_drained", 32'(gen_dut[1].sb_q.size()), 32'd0);
        check("s4_err_ovf_end", 32'(err_ovf[1]), 32'd0);

        // Scenario 5: asynchronous reset at cycle 16 of a single read
        step();
        rd_req[0] = 1'b1;
        rd_tag[0] = 4'd6;
        @(negedge clk);
        base = cyc;
        check("s5_gnt", 32'(rd_gnt[0]), 32'd1);
        step();
        rd_req[0] = 1'b0;
        repeat (15) step();
        check("s5_mid_drain_valid", 32'(rd_valid[0]), 32'd1);
        check("s5_mid_drain_cycle", cyc, base + 32'd16);
        reset_n = 1'b0;
        #1;
        check_zero(0, "s5_async");
        @(negedge clk);
        step();
        reset_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("s5_post_listen_t%0d", t), 32'(listen[0]), 32'd0);
            check($sformatf("s5_post_valid_t%0d", t), 32'(rd_valid[0]), 32'd0);
        end
        run_single(0, 4'd5, 11, 2);
        check("s5_drained", 32'(gen_dut[0].sb_q.size()), 32'd0);

        // Scenario 6: RL=2, DRAIN_DLY=1, single read then back-to-back pair
        run_single(2, 4'hA, 2, 1);
        step();
        rd_req[2] = 1'b1;
        for (int t = 0; t < 9; t++) begin
            rd_tag[2] = 4'(t + 1);
            @(negedge clk);
            check($sformatf("s6_gnt_t%0d", t), 32'(rd_gnt[2]), 32'((t % 8) == 0));
            step();
        end
        rd_req[2] = 1'b0;
        wait_idle(2);
        check("s6_drained", 32'(gen_dut[2].sb_q.size()), 32'd0);

        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("d%0d_final_err_ovf", i), 32'(err_ovf[i]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
